scr1_pipe_lsu_mo: RTL

Multiple-outstanding Load/Store Unit. It sits between EXU and the DMEM port and keeps up to SCR1_LSU_OUTSTD_NUM DMEM transactions in flight. An in-order tracking FIFO holds command and address offset for each in-flight transaction. The block does load byte-lane extraction, store lane replication, misalign exceptions, access-fault exceptions and pipeline-flush kill of pending responses.

---
 rtl/scr1_pipe_lsu_mo.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/scr1_pipe_lsu_mo.sv
// Multiple-outstanding load/store unit between EXU and the DMEM port, with an in-order tracking FIFO.
// Optional macro SCR1_TDU_EN adds the trigger-unit data monitor and breakpoint exception path.

module scr1_pipe_lsu_mo_chk (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] resp,
    input  logic       fifo_empty
);

    resp_without_pending : assert property (@(posedge clk) disable iff (!rst_n)
        (resp != 2'd0) |-> !fifo_empty);

endmodule

module scr1_pipe_lsu_mo #(
    parameter int SCR1_LSU_OUTSTD_NUM = 2,
    localparam int SCR1_LSU_CNT_W = $clog2(SCR1_LSU_OUTSTD_NUM + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exu2lsu_req_i,
    input  logic [3:0]  exu2lsu_cmd_i,
    input  logic [31:0] exu2lsu_addr_i,
    input  logic [31:0] exu2lsu_sdata_i,
    input  logic        exu2lsu_flush_i,
    output logic        lsu2exu_req_ack_o,
    output logic        lsu2exu_rdy_o,
    output logic [31:0] lsu2exu_ldata_o,
    output logic        lsu2exu_exc_o,
    output logic [3:0]  lsu2exu_exc_code_o,
`ifdef SCR1_TDU_EN
    output logic [34:0] lsu2tdu_dmon_o,
    input  logic        tdu2lsu_ibrkpt_exc_req_i,
    input  logic        tdu2lsu_dbrkpt_exc_req_i,
`endif
    output logic        lsu2dmem_req_o,
    output logic        lsu2dmem_cmd_o,
    output logic [1:0]  lsu2dmem_width_o,
    output logic [31:0] lsu2dmem_addr_o,
    output logic [31:0] lsu2dmem_wdata_o,
    input  logic        dmem2lsu_req_ack_i,
    input  logic [31:0] dmem2lsu_rdata_i,
    input  logic [1:0]  dmem2lsu_resp_i
);

    localparam int N     = SCR1_LSU_OUTSTD_NUM;
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [3:0] CMD_LB  = 4'd1, CMD_LH  = 4'd2, CMD_LW = 4'd3, CMD_LBU = 4'd4,
                           CMD_LHU = 4'd5, CMD_SB  = 4'd6, CMD_SH = 4'd7, CMD_SW  = 4'd8;
    localparam logic [1:0] W_BYTE = 2'd0, W_HWORD = 2'd1, W_WORD = 2'd2;
    localparam logic [1:0] RESP_NOTRDY = 2'd0, RESP_ER = 2'd2;
    localparam logic [3:0] EXC_INSTR_MIS = 4'd0, EXC_BRKPT = 4'd3, EXC_LD_MIS = 4'd4,
                           EXC_LD_AF = 4'd5, EXC_ST_MIS = 4'd6, EXC_ST_AF = 4'd7;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(N - 1)) return {PTR_W{1'b0}};
        else                    return p + PTR_W'(1);
    endfunction

    logic [SCR1_LSU_CNT_W-1:0] cnt_r;
    logic [PTR_W-1:0]          wptr_r, rptr_r;
    logic [3:0]                fifo_cmd_r [N];
    logic [1:0]                fifo_off_r [N];
    logic [N-1:0]              fifo_kill_r;

    logic        empty_s, full_s, is_store_s, misalign_s, brk_s;
    logic        brk_exc_s, mis_exc_s, dmem_req_s, push_s, pop_s, live_s, fault_s;
    logic [1:0]  width_s;
    logic [3:0]  head_cmd_s;
    logic [1:0]  head_off_s;
    logic [31:0] sh_s;

    assign empty_s    = (cnt_r == {SCR1_LSU_CNT_W{1'b0}});
    assign full_s     = (cnt_r == SCR1_LSU_CNT_W'(N));
    assign head_cmd_s = fifo_cmd_r[rptr_r];
    assign head_off_s = fifo_off_r[rptr_r];

`ifdef SCR1_TDU_EN
    assign brk_s = exu2lsu_req_i & (tdu2lsu_ibrkpt_exc_req_i | tdu2lsu_dbrkpt_exc_req_i);
    assign lsu2tdu_dmon_o = {exu2lsu_req_i & empty_s & ~tdu2lsu_ibrkpt_exc_req_i,
                             exu2lsu_addr_i,
                             exu2lsu_req_i & (exu2lsu_cmd_i inside {CMD_LB, CMD_LBU, CMD_LH, CMD_LHU, CMD_LW}),
                             exu2lsu_req_i & is_store_s};
`else
    assign brk_s = 1'b0;
`endif

    // Command decode into access width and direction
    always_comb begin
        is_store_s = 1'b0;
        width_s    = W_WORD;
        case (exu2lsu_cmd_i)
            CMD_LB, CMD_LBU: width_s = W_BYTE;
            CMD_LH, CMD_LHU: width_s = W_HWORD;
            CMD_SB:  begin is_store_s = 1'b1; width_s = W_BYTE;  end
            CMD_SH:  begin is_store_s = 1'b1; width_s = W_HWORD; end
            CMD_SW:  begin is_store_s = 1'b1; width_s = W_WORD;  end
            default: width_s = W_WORD;
        endcase
    end

    // Request-side exceptions only fire with nothing in flight so they stay precise
    assign misalign_s = exu2lsu_req_i & (((width_s == W_HWORD) & exu2lsu_addr_i[0])
                                       | ((width_s == W_WORD) & (exu2lsu_addr_i[1:0] != 2'b00)));
    assign brk_exc_s  = brk_s & empty_s;
    assign mis_exc_s  = misalign_s & empty_s;
    assign dmem_req_s = exu2lsu_req_i & ~misalign_s & ~brk_s & ~full_s & ~exu2lsu_flush_i;
    assign push_s     = dmem_req_s & dmem2lsu_req_ack_i;
    assign pop_s      = (dmem2lsu_resp_i != RESP_NOTRDY) & ~empty_s;
    assign live_s     = pop_s & ~fifo_kill_r[rptr_r];
    assign fault_s    = live_s & (dmem2lsu_resp_i == RESP_ER);
    assign sh_s       = dmem2lsu_rdata_i >> {head_off_s, 3'b000};

    assign lsu2exu_req_ack_o = push_s | mis_exc_s | brk_exc_s;
    assign lsu2exu_rdy_o     = live_s;
    assign lsu2exu_exc_o     = fault_s | brk_exc_s | mis_exc_s;
    assign lsu2dmem_req_o    = dmem_req_s;
    assign lsu2dmem_cmd_o    = exu2lsu_req_i & is_store_s;
    assign lsu2dmem_width_o  = exu2lsu_req_i ? width_s : W_BYTE;
    assign lsu2dmem_addr_o   = exu2lsu_req_i ? exu2lsu_addr_i : 32'd0;

    // Exception code priority and load data alignment/extension
    always_comb begin
        lsu2exu_exc_code_o = EXC_INSTR_MIS;
        lsu2exu_ldata_o    = 32'd0;
        if (fault_s) begin
            lsu2exu_exc_code_o = (head_cmd_s inside {CMD_SB, CMD_SH, CMD_SW}) ? EXC_ST_AF : EXC_LD_AF;
        end else if (brk_exc_s) begin
            lsu2exu_exc_code_o = EXC_BRKPT;
        end else if (mis_exc_s) begin
            lsu2exu_exc_code_o = is_store_s ? EXC_ST_MIS : EXC_LD_MIS;
        end else begin
            lsu2exu_exc_code_o = EXC_INSTR_MIS;
        end
        if (live_s) begin
            case (head_cmd_s)
                CMD_LB:  lsu2exu_ldata_o = {{24{sh_s[7]}}, sh_s[7:0]};
                CMD_LBU: lsu2exu_ldata_o = {24'd0, sh_s[7:0]};
                CMD_LH:  lsu2exu_ldata_o = {{16{sh_s[15]}}, sh_s[15:0]};
                CMD_LHU: lsu2exu_ldata_o = {16'd0, sh_s[15:0]};
                default: lsu2exu_ldata_o = sh_s;
            endcase
        end else begin
            lsu2exu_ldata_o = 32'd0;
        end
    end

    // Store data replicated onto every lane the access width can land on
    always_comb begin
        lsu2dmem_wdata_o = 32'd0;
        if (exu2lsu_req_i) begin
            case (width_s)
                W_BYTE:  lsu2dmem_wdata_o = {4{exu2lsu_sdata_i[7:0]}};
                W_HWORD: lsu2dmem_wdata_o = {2{exu2lsu_sdata_i[15:0]}};
                default: lsu2dmem_wdata_o = exu2lsu_sdata_i;
            endcase
        end else begin
            lsu2dmem_wdata_o = 32'd0;
        end
    end

    // Tracking FIFO: pointers, occupancy and per-entry kill bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r       <= {SCR1_LSU_CNT_W{1'b0}};
            wptr_r      <= {PTR_W{1'b0}};
            rptr_r      <= {PTR_W{1'b0}};
            fifo_kill_r <= {N{1'b0}};
            for (int i = 0; i < N; i++) begin
                fifo_cmd_r[i] <= 4'd0;
                fifo_off_r[i] <= 2'd0;
            end
        end else begin
            if (push_s) begin
                fifo_cmd_r[wptr_r] <= exu2lsu_cmd_i;
                fifo_off_r[wptr_r] <= exu2lsu_addr_i[1:0];
                wptr_r             <= ptr_inc(wptr_r);
            end
            if (pop_s) begin
                rptr_r <= ptr_inc(rptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + SCR1_LSU_CNT_W'(1);
                2'b01:   cnt_r <= cnt_r - SCR1_LSU_CNT_W'(1);
                default: cnt_r <= cnt_r;
            endcase
            for (int i = 0; i < N; i++) begin
                if (exu2lsu_flush_i) begin
                    fifo_kill_r[i] <= 1'b1;
                end else if (push_s && (wptr_r == PTR_W'(i))) begin
                    fifo_kill_r[i] <= 1'b0;
                end
            end
        end
    end

    scr1_pipe_lsu_mo_chk u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .resp       (dmem2lsu_resp_i),
        .fifo_empty (empty_s)
    );

endmodule
